// File: rtl/apb_master_nslv.sv
// APB master bridge: accepts one local request at a time and runs a single SETUP/ACCESS
// transfer to one of NUM_SLAVES slaves, returning a registered response pulse with status.
module apb_master_nslv #(
    parameter int unsigned ADDR_WIDTH     = 9,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned NUM_SLAVES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic                             PCLK,
    input  logic                             PRESET,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    output logic                             rsp_valid,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic [1:0]                       rsp_code,
    output logic [NUM_SLAVES-1:0]            PSEL,
    output logic                             PENABLE,
    output logic [ADDR_WIDTH-1:0]            PADDR,
    output logic                             PWRITE,
    output logic [DATA_WIDTH-1:0]            PWDATA,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]            PREADY,
    input  logic [NUM_SLAVES-1:0]            PSLVERR
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_SLVERR  = 2'b01;
    localparam logic [1:0] CODE_DECERR  = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic                    pwrite_q, pwrite_d;
    logic [DATA_WIDTH-1:0]   pwdata_q, pwdata_d;
    logic [SEL_W-1:0]        sel_q, sel_d;
    logic [NUM_SLAVES-1:0]   psel_q, psel_d;
    logic                    penable_q, penable_d;
    logic [CNT_W-1:0]        wait_q, wait_d;
    logic                    rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_code_q, rsp_code_d;

    logic [SEL_W-1:0]        req_idx;
    logic                    dec_err;
    logic                    sel_ready;
    logic                    sel_err;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic [CNT_W-1:0]        wait_inc;
    logic                    timeout_hit;

    assign req_idx = req_addr[ADDR_WIDTH-1 -: SEL_W];
    assign dec_err = (32'(req_idx) >= NUM_SLAVES);

    // Only the slave latched at accept time is observed; all other slaves are ignored.
    always_comb begin
        sel_ready = 1'b0;
        sel_err   = 1'b0;
        sel_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ready = PREADY[i];
                sel_err   = PSLVERR[i];
                sel_rdata = PRDATA[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign wait_inc    = (wait_q == '1) ? wait_q : wait_q + CNT_W'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && ((32'(wait_q) + 32'd1) == TIMEOUT_CYCLES);

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= IDLE;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            sel_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            wait_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_code_q  <= CODE_OK;
        end else begin
            state_q     <= state_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            wait_q      <= wait_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_code_q  <= rsp_code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid && !dec_err) state_d = SETUP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (sel_ready || timeout_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A ready slave takes priority over timeout expiry on the same cycle.
    always_comb begin
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        sel_d       = sel_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        wait_d      = wait_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_code_d  = rsp_code_q;
        case (state_q)
            IDLE: begin
                psel_d    = '0;
                penable_d = 1'b0;
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwrite_d = req_write;
                    pwdata_d = req_write ? req_wdata : '0;
                    sel_d    = req_idx;
                    wait_d   = '0;
                    if (dec_err) begin
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = CODE_DECERR;
                        rsp_rdata_d = '0;
                    end else begin
                        psel_d = NUM_SLAVES'(1'b1) << req_idx;
                    end
                end
            end
            SETUP: penable_d = 1'b1;
            ACCESS: begin
                if (sel_ready) begin
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_code_d  = sel_err ? CODE_SLVERR : CODE_OK;
                    rsp_rdata_d = pwrite_q ? '0 : sel_rdata;
                end else begin
                    wait_d = wait_inc;
                    if (timeout_hit) begin
                        psel_d      = '0;
                        penable_d   = 1'b0;
                        rsp_valid_d = 1'b1;
                        rsp_code_d  = CODE_TIMEOUT;
                        rsp_rdata_d = '0;
                    end
                end
            end
            default: begin
                psel_d    = '0;
                penable_d = 1'b0;
            end
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_code  = rsp_code_q;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PADDR     = paddr_q;
    assign PWRITE    = pwrite_q;
    assign PWDATA    = pwdata_q;

endmodule

// File: tb/tb_apb_master_nslv.sv
// Scoreboard bench for apb_master_nslv with three slaves and a four-cycle PREADY timeout.
module tb_apb_master_nslv;

    localparam int AW = 9;
    localparam int DW = 8;
    localparam int NS = 3;
    localparam int TO = 4;
    localparam int IDX_SHIFT = 7;

    logic           PCLK;
    logic           PRESET;
    logic           req_valid;
    logic           req_ready;
    logic           req_write;
    logic [AW-1:0]  req_addr;
    logic [DW-1:0]  req_wdata;
    logic           rsp_valid;
    logic [DW-1:0]  rsp_rdata;
    logic [1:0]     rsp_code;
    logic [NS-1:0]  PSEL;
    logic           PENABLE;
    logic [AW-1:0]  PADDR;
    logic           PWRITE;
    logic [DW-1:0]  PWDATA;
    logic [NS*DW-1:0] PRDATA;
    logic [NS-1:0]  PREADY;
    logic [NS-1:0]  PSLVERR;

    typedef struct {
        logic [1:0]    code;
        logic [DW-1:0] rdata;
        int            due;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    bit            mon_en = 1'b0;
    logic [1:0]    last_code = 2'b00;
    logic [DW-1:0] last_rdata = '0;

    int            cur_idx = -1;
    int            cur_waits = 0;
    int            access_count = 0;
    bit            cur_err = 1'b0;
    logic [DW-1:0] cur_rdata = '0;

    apb_master_nslv #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SLAVES(NS), .TIMEOUT_CYCLES(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
        .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Slave model: non-selected slaves drive noise; the selected one holds PREADY low for cur_waits ACCESS cycles.
    always @(negedge PCLK) begin : slave_model
        bit rdy;
        for (int i = 0; i < NS; i++) begin
            PREADY[i]          = 1'($urandom);
            PSLVERR[i]         = 1'($urandom);
            PRDATA[i*DW +: DW] = 8'($urandom);
        end
        if (cur_idx >= 0 && cur_idx < NS) begin
            if (PENABLE === 1'b1 && PSEL[cur_idx] === 1'b1) begin
                rdy = (access_count >= cur_waits);
                access_count++;
                PREADY[cur_idx] = rdy;
                if (rdy) begin
                    PSLVERR[cur_idx]         = cur_err;
                    PRDATA[cur_idx*DW +: DW] = cur_rdata;
                end
            end
        end
    end

    // Monitor: pops the expected response whenever the bridge pulses rsp_valid.
    always @(negedge PCLK) begin : monitor
        exp_t e;
        if (mon_en) begin
            if (rsp_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_rsp: got rsp_valid=1, expected none (cycle %0d)", cyc);
                end else begin
                    e = sb_q.pop_front();
                    checkOutput("rsp_code", 32'(rsp_code), 32'(e.code));
                    checkOutput("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
                    checkOutput("rsp_latency", cyc, e.due);
                    checkOutput("bus_idle_at_rsp", {28'd0, PENABLE, PSEL}, 32'd0);
                    last_code  = e.code;
                    last_rdata = e.rdata;
                end
            end else if (PRESET !== 1'b1) begin
                checkOutput("rsp_hold", {22'd0, rsp_code, rsp_rdata}, {22'd0, last_code, last_rdata});
            end
        end
    end

    task automatic applyStimulus(input bit wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                                 input int waits, input bit err, input logic [DW-1:0] rdata,
                                 input bit expect_rsp);
        int   guard;
        int   idx;
        exp_t e;
        guard = 0;
        idx = int'(addr) >> IDX_SHIFT;
        while (req_ready !== 1'b1 && guard < 50) begin
            @(negedge PCLK);
            guard++;
        end
        if (guard >= 50) begin
            checks++;
            errors++;
            $display("[TB] FAIL req_ready_wait: got req_ready=%b, expected 1 within 50 cycles", req_ready);
            return;
        end
        cur_idx      = idx;
        cur_waits    = waits;
        cur_err      = err;
        cur_rdata    = rdata;
        access_count = 0;
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        if (idx >= NS) begin
            e.code = 2'b10; e.rdata = '0; e.due = cyc + 1;
        end else if (waits >= TO) begin
            e.code = 2'b11; e.rdata = '0; e.due = cyc + 2 + TO;
        end else begin
            e.code  = err ? 2'b01 : 2'b00;
            e.rdata = wr ? '0 : rdata;
            e.due   = cyc + 3 + waits;
        end
        if (expect_rsp) sb_q.push_back(e);
        @(posedge PCLK);
        #1;
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = 9'($urandom);
        req_wdata = 8'($urandom);
        @(negedge PCLK);
        checkOutput("setup_psel", 32'(PSEL), (idx >= NS) ? 32'd0 : (32'd1 << idx));
        checkOutput("setup_penable", 32'(PENABLE), 32'd0);
        checkOutput("setup_paddr", 32'(PADDR), 32'(addr));
        checkOutput("setup_pwrite", 32'(PWRITE), 32'(wr));
        checkOutput("setup_pwdata", 32'(PWDATA), wr ? 32'(wdata) : 32'd0);
        checkOutput("setup_req_ready", 32'(req_ready), (idx >= NS) ? 32'd1 : 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        checkOutput({tag, "_psel"}, 32'(PSEL), 32'd0);
        checkOutput({tag, "_penable"}, 32'(PENABLE), 32'd0);
        checkOutput({tag, "_paddr"}, 32'(PADDR), 32'd0);
        checkOutput({tag, "_pwrite"}, 32'(PWRITE), 32'd0);
        checkOutput({tag, "_pwdata"}, 32'(PWDATA), 32'd0);
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_rsp_rdata"}, 32'(rsp_rdata), 32'd0);
        checkOutput({tag, "_rsp_code"}, 32'(rsp_code), 32'd0);
        checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    endtask

    initial begin : watchdog
        repeat (20000) @(posedge PCLK);
        checks++;
        errors++;
        $display("[TB] FAIL watchdog: got no end of test, expected finish within 20000 cycles");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin : main
        int guard;
        PRESET    = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        repeat (3) @(negedge PCLK);
        check_reset_values("reset");
        PRESET = 1'b0;
        mon_en = 1'b1;
        @(negedge PCLK);

        $display("[TB] directed transfers");
        applyStimulus(1'b1, 9'h012, 8'hA5, 0, 1'b0, 8'h00, 1'b1);
        applyStimulus(1'b0, 9'h085, 8'hFF, 2, 1'b0, 8'h3C, 1'b1);
        applyStimulus(1'b0, 9'h1C0, 8'h5A, 0, 1'b0, 8'h99, 1'b1);
        applyStimulus(1'b0, 9'h040, 8'h00, 1, 1'b0, 8'hC3, 1'b1);
        applyStimulus(1'b1, 9'h105, 8'h66, TO, 1'b0, 8'h12, 1'b1);
        applyStimulus(1'b0, 9'h110, 8'h00, TO - 1, 1'b0, 8'hE1, 1'b1);
        applyStimulus(1'b0, 9'h0AA, 8'h00, 0, 1'b1, 8'h77, 1'b1);

        $display("[TB] reset during ACCESS");
        applyStimulus(1'b0, 9'h085, 8'h00, TO + 2, 1'b0, 8'h11, 1'b0);
        @(negedge PCLK);
        checkOutput("access_penable", 32'(PENABLE), 32'd1);
        PRESET     = 1'b1;
        last_code  = 2'b00;
        last_rdata = '0;
        @(negedge PCLK);
        PRESET = 1'b0;
        check_reset_values("midreset");
        cur_idx = -1;
        repeat (8) @(negedge PCLK);
        applyStimulus(1'b1, 9'h033, 8'h3E, 0, 1'b0, 8'h00, 1'b1);

        $display("[TB] random transfers");
        for (int n = 0; n < 40; n++) begin
            applyStimulus(1'($urandom), 9'($urandom), 8'($urandom),
                          int'($urandom_range(0, TO + 2)), 1'($urandom), 8'($urandom), 1'b1);
        end

        guard = 0;
        while (sb_q.size() > 0 && guard < 100) begin
            @(negedge PCLK);
            guard++;
        end
        while (sb_q.size() > 0) begin
            void'(sb_q.pop_front());
            checks++;
            errors++;
            $display("[TB] FAIL missing_rsp: got no rsp_valid, expected a pending response");
        end
        repeat (2) @(negedge PCLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
